// File: rtl/gpio_mmio_port.sv
// Memory-mapped GPIO responder: synchronized, debounced switch inputs with sticky
// rising-edge flags, software-driven LED outputs, and a masked edge interrupt.
module gpio_mmio_port #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sel_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [3:0]       addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic             rvalid_o,
    input  logic [WIDTH-1:0] GPIO_i,
    output logic [WIDTH-1:0] GPIO_o,
    output logic             edge_irq_o
);

    localparam logic [1:0] REG_OUT  = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_MASK = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic {
        IDLE,
        COUNT
    } deb_state_e;

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic             wr_en;
    logic             rd_en;
    logic [1:0]       reg_sel;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rise;
    logic [31:0]      rd_word;
    logic             unused_bits;

    assign wr_en   = sel_i & we_i;
    assign rd_en   = sel_i & re_i;
    assign reg_sel = addr_i[3:2];

    // Byte-offset bits and store bits above WIDTH carry no meaning here.
    assign unused_bits = &{1'b0, addr_i[1:0], wdata_i};

    // Input synchronizer and whole-vector debounce.
    always_comb begin
        sync1_d = GPIO_i;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        deb_d   = deb_q;
        case (state_q)
            IDLE: begin
                if (sync2_q != deb_q) begin
                    state_d = COUNT;
                    cand_d  = sync2_q;
                    cnt_d   = CNT_ONE;
                end
            end
            COUNT: begin
                // Falling back to the accepted value abandons the candidate outright.
                if (sync2_q == deb_q) begin
                    state_d = IDLE;
                end else if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    deb_d   = cand_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rise = deb_d & ~deb_q;

    // Register writes; a fresh rising edge outranks a same-cycle W1C.
    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        edge_clr = '0;
        if (wr_en) begin
            case (reg_sel)
                REG_OUT:  out_d    = wdata_i[WIDTH-1:0];
                REG_EDGE: edge_clr = wdata_i[WIDTH-1:0];
                REG_MASK: mask_d   = wdata_i[WIDTH-1:0];
                default:  ;
            endcase
        end
        edge_d = (edge_q & ~edge_clr) | rise;
    end

    // Reads use pre-write state, so a combined load/store returns the old value.
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_OUT:  rd_word[WIDTH-1:0] = out_q;
            REG_IN:   rd_word[WIDTH-1:0] = deb_q;
            REG_EDGE: rd_word[WIDTH-1:0] = edge_q;
            REG_MASK: rd_word[WIDTH-1:0] = mask_q;
            default:  rd_word = '0;
        endcase
        rdata_d  = rd_en ? rd_word : rdata_q;
        rvalid_d = rd_en;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            deb_q    <= '0;
            out_q    <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            deb_q    <= deb_d;
            out_q    <= out_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign GPIO_o     = out_q;
    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;
    assign edge_irq_o = |(edge_q & mask_q);

endmodule

// File: tb/tb_gpio_mmio_port.sv
// Self-checking bench for gpio_mmio_port: directed scenarios plus randomized traffic
// compared against a run-length behavioural model of the input path and register map.
module tb_gpio_mmio_port;
    localparam int W     = 8;
    localparam int DEB   = 4;
    localparam int CNT_W = 3;
    localparam int LAT   = 2 + DEB + 1;
    localparam logic [3:0] A_OUT  = 4'h0;
    localparam logic [3:0] A_IN   = 4'h4;
    localparam logic [3:0] A_EDGE = 4'h8;
    localparam logic [3:0] A_MASK = 4'hC;

    logic          clk_i   = 1'b0;
    logic          reset_i = 1'b1;
    logic          sel_i   = 1'b0;
    logic          we_i    = 1'b0;
    logic          re_i    = 1'b0;
    logic [3:0]    addr_i  = '0;
    logic [31:0]   wdata_i = '0;
    logic [W-1:0]  gpio_in = '0;
    logic [31:0]   rdata_o;
    logic          rvalid_o;
    logic [W-1:0]  GPIO_o;
    logic          edge_irq_o;

    int checks = 0;
    int errors = 0;

    gpio_mmio_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .sel_i(sel_i), .we_i(we_i), .re_i(re_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .GPIO_i(gpio_in), .GPIO_o(GPIO_o), .edge_irq_o(edge_irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a value is accepted once the synchronized input (pins delayed
    // two edges) has shown it on DEB+1 consecutive edges and it differs from IN.
    logic [W-1:0] m_p1, m_p2, m_run_val, m_deb, m_edge, m_mask, m_out;
    int           m_run_len;
    logic [31:0]  m_rdata;
    logic         m_rvalid;

    always @(posedge clk_i) begin
        logic [W-1:0] s, nd, clr;
        logic [31:0]  rd;
        if (reset_i) begin
            m_p1 = '0; m_p2 = '0; m_run_val = '0; m_run_len = 0;
            m_deb = '0; m_edge = '0; m_mask = '0; m_out = '0;
            m_rdata = '0; m_rvalid = 1'b0;
        end else begin
            s = m_p2; m_p2 = m_p1; m_p1 = gpio_in;
            if (s == m_run_val) m_run_len++;
            else begin m_run_val = s; m_run_len = 1; end
            nd = (m_run_len > DEB && m_run_val != m_deb) ? m_run_val : m_deb;
            rd = '0;
            case (addr_i[3:2])
                2'd0: rd[W-1:0] = m_out;
                2'd1: rd[W-1:0] = m_deb;
                2'd2: rd[W-1:0] = m_edge;
                default: rd[W-1:0] = m_mask;
            endcase
            m_rvalid = sel_i & re_i;
            if (m_rvalid) m_rdata = rd;
            clr = '0;
            if (sel_i && we_i) begin
                case (addr_i[3:2])
                    2'd0: m_out = wdata_i[W-1:0];
                    2'd2: clr = wdata_i[W-1:0];
                    2'd3: m_mask = wdata_i[W-1:0];
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~clr) | (nd & ~m_deb);
            m_deb = nd;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        sel_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        sel_i = 1'b1; we_i = 1'b1; re_i = 1'b0; addr_i = a; wdata_i = d;
        tick();
        idle();
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [31:0] d, output logic v);
        sel_i = 1'b1; we_i = 1'b0; re_i = 1'b1; addr_i = a;
        tick();
        d = rdata_o; v = rvalid_o;
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        reset_i = 1'b1; gpio_in = '0; idle();
        repeat (3) tick();
        checks++;
        if (GPIO_o !== '0 || rdata_o !== '0 || rvalid_o !== 1'b0 || edge_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: GPIO_o=%h rdata=%h rvalid=%b irq=%b expected all 0",
                     GPIO_o, rdata_o, rvalid_o, edge_irq_o);
        end
        reset_i = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) begin
            read_reg(4'(a * 4), d, v);
            checks++;
            if (v !== 1'b1 || d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d: rdata=%h rvalid=%b expected 00000000/1", a, d, v);
            end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d, exp; logic v;
        gpio_in = '0;
        repeat (12) tick();
        gpio_in = 8'h07;
        sel_i = 1'b1; re_i = 1'b1; addr_i = A_IN;
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            exp = (k >= LAT + 1) ? 32'h7 : 32'h0;
            checks++;
            if (rvalid_o !== 1'b1 || rdata_o !== exp) begin
                errors++;
                $display("FAIL debounce_in k=%0d: rdata=%h rvalid=%b expected %h/1", k, rdata_o, rvalid_o, exp);
            end
        end
        idle();
        read_reg(A_EDGE, d, v);
        checks++;
        if (d !== 32'h7) begin
            errors++; $display("FAIL debounce_edge: rdata=%h expected 00000007", d);
        end
    endtask

    task automatic test_out();
        write_reg(A_OUT, 32'hA5);
        checks++;
        if (GPIO_o !== 8'hA5 || rvalid_o !== 1'b0) begin
            errors++; $display("FAIL out_write: GPIO_o=%h rvalid=%b expected a5/0", GPIO_o, rvalid_o);
        end
        sel_i = 1'b1; re_i = 1'b1; addr_i = A_OUT;
        tick();
        idle();
        checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'hA5) begin
            errors++; $display("FAIL out_read: rdata=%h rvalid=%b expected 000000a5/1", rdata_o, rvalid_o);
        end
        tick();
        checks++;
        if (rvalid_o !== 1'b0 || rdata_o !== 32'hA5) begin
            errors++; $display("FAIL out_hold: rdata=%h rvalid=%b expected 000000a5/0", rdata_o, rvalid_o);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d; logic v;
        gpio_in = 8'h00;
        repeat (LAT + 3) tick();
        write_reg(A_EDGE, 32'hFF);
        for (int g = 0; g < 4; g++) begin
            gpio_in = (g % 2 == 0) ? 8'h01 : 8'h00;
            repeat (2) tick();
        end
        repeat (LAT + 3) tick();
        read_reg(A_IN, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL glitch_in: rdata=%h expected 00000000", d); end
        read_reg(A_EDGE, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL glitch_edge: rdata=%h expected 00000000", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic v;
        gpio_in = 8'h07;
        repeat (LAT + 2) tick();
        write_reg(A_MASK, 32'h02);
        checks++;
        if (edge_irq_o !== 1'b1) begin errors++; $display("FAIL irq_set: irq=%b expected 1", edge_irq_o); end
        write_reg(A_EDGE, 32'h02);
        checks++;
        if (edge_irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear: irq=%b expected 0", edge_irq_o); end
        read_reg(A_EDGE, d, v);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL w1c_edge: rdata=%h expected 00000005", d); end
        gpio_in = 8'h06;
        repeat (LAT + 2) tick();
        read_reg(A_EDGE, d, v);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL fall_noflag: rdata=%h expected 00000005", d); end
        // New bit-0 rise lands on the same edge as the W1C of bit 0.
        gpio_in = 8'h07;
        repeat (LAT - 1) tick();
        write_reg(A_EDGE, 32'h01);
        read_reg(A_EDGE, d, v);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL set_wins: rdata=%h expected 00000005", d); end
        write_reg(A_EDGE, 32'h01);
        read_reg(A_EDGE, d, v);
        checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL w1c_bit0: rdata=%h expected 00000004", d); end
    endtask

    task automatic test_rw_same();
        logic [31:0] d; logic v;
        write_reg(A_OUT, 32'h11);
        sel_i = 1'b1; we_i = 1'b1; re_i = 1'b1; addr_i = A_OUT; wdata_i = 32'h22;
        tick();
        idle();
        checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'h11 || GPIO_o !== 8'h22) begin
            errors++;
            $display("FAIL rw_same: rdata=%h rvalid=%b GPIO_o=%h expected 00000011/1/22", rdata_o, rvalid_o, GPIO_o);
        end
        sel_i = 1'b0; we_i = 1'b1; re_i = 1'b1; addr_i = A_OUT; wdata_i = 32'h33;
        repeat (2) begin
            tick();
            checks++;
            if (rvalid_o !== 1'b0 || GPIO_o !== 8'h22) begin
                errors++; $display("FAIL unsel: rvalid=%b GPIO_o=%h expected 0/22", rvalid_o, GPIO_o);
            end
        end
        idle();
        read_reg(A_OUT, d, v);
        checks++;
        if (d !== 32'h22) begin errors++; $display("FAIL unsel_out: rdata=%h expected 00000022", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, exp; logic v;
        gpio_in = 8'h00;
        repeat (LAT + 3) tick();
        write_reg(A_OUT, 32'h5A);
        write_reg(A_MASK, 32'hFF);
        gpio_in = 8'hFF;
        repeat (3) tick();
        sel_i = 1'b1; re_i = 1'b1; addr_i = A_IN;
        tick();
        checks++;
        if (rvalid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_read: rvalid=%b expected 1", rvalid_o); end
        // Reset coincides with a store and follows a load; both must be dropped.
        reset_i = 1'b1; we_i = 1'b1; re_i = 1'b1; addr_i = A_OUT; wdata_i = 32'hFF;
        tick();
        reset_i = 1'b0; idle();
        checks++;
        if (GPIO_o !== '0 || rdata_o !== '0 || rvalid_o !== 1'b0 || edge_irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: GPIO_o=%h rdata=%h rvalid=%b irq=%b expected all 0",
                     GPIO_o, rdata_o, rvalid_o, edge_irq_o);
        end
        sel_i = 1'b1; re_i = 1'b1; addr_i = A_IN;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick();
            exp = (k >= LAT + 1) ? 32'hFF : 32'h0;
            checks++;
            if (rvalid_o !== 1'b1 || rdata_o !== exp) begin
                errors++;
                $display("FAIL reset_redeb k=%0d: rdata=%h rvalid=%b expected %h/1", k, rdata_o, rvalid_o, exp);
            end
        end
        idle();
        read_reg(A_OUT, d, v);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_out: rdata=%h expected 00000000", d); end
    endtask

    task automatic test_back_to_back();
        write_reg(A_OUT, $urandom);
        write_reg(A_MASK, $urandom);
        sel_i = 1'b1; re_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            addr_i = 4'($urandom);
            tick();
            checks++;
            if (rvalid_o !== 1'b1 || rdata_o !== m_rdata) begin
                errors++;
                $display("FAIL b2b k=%0d: rdata=%h rvalid=%b expected %h/1", k, rdata_o, rvalid_o, m_rdata);
            end
        end
        idle();
    endtask

    task automatic test_random();
        int hold = 0;
        logic exp_irq;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                gpio_in = ($urandom_range(0, 1) == 0) ? W'($urandom) : (gpio_in ^ W'(1 << $urandom_range(0, W - 1)));
                hold = $urandom_range(1, 10);
            end
            hold--;
            reset_i = ($urandom_range(0, 199) == 0);
            sel_i   = ($urandom_range(0, 3) != 0);
            we_i    = ($urandom_range(0, 2) == 0);
            re_i    = $urandom_range(0, 1) == 1;
            addr_i  = 4'($urandom);
            wdata_i = $urandom;
            tick();
            exp_irq = |(m_edge & m_mask);
            checks++;
            if (GPIO_o !== m_out || rvalid_o !== m_rvalid || rdata_o !== m_rdata || edge_irq_o !== exp_irq) begin
                errors++;
                $display("FAIL random c=%0d: GPIO_o=%h rvalid=%b rdata=%h irq=%b expected %h/%b/%h/%b",
                         c, GPIO_o, rvalid_o, rdata_o, edge_irq_o, m_out, m_rvalid, m_rdata, exp_irq);
            end
        end
        reset_i = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_out();
        test_glitch();
        test_irq();
        test_rw_same();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_mmio_port.md
Name: gpio_mmio_port

Overview:
Memory-mapped GPIO responder on the mips data bus. It serves core load/store accesses to the 8-bit switch input and LED output pins. It synchronizes and debounces GPIO_i, drives GPIO_o from a software-written register, and latches sticky rising-edge flags so firmware can poll for switch presses. It sits beside data memory in the mips address decode and is selected by sel_i.

Parameters:
WIDTH, 8, GPIO pin count (GPIO_i and GPIO_o width, max 32).
DEBOUNCE_CYCLES, 4, consecutive clk_i cycles the synchronized input must be unchanged before it is accepted (min 1).
CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk_i  input  1  system clock; all logic on its rising edge.
reset_i  input  1  synchronous, active-high reset.
sel_i  input  1  block selected by the core's address decode.
we_i  input  1  store strobe; qualified by sel_i.
re_i  input  1  load strobe; qualified by sel_i.
addr_i  input  4  byte address within the block; bits [3:2] select the register, bits [1:0] are ignored.
wdata_i  input  32  store data.
rdata_o  output  32  load data, registered.
rvalid_o  output  1  one-cycle pulse when rdata_o holds a load result.
GPIO_i  input  WIDTH  asynchronous switch inputs.
GPIO_o  output  WIDTH  LED outputs.
edge_irq_o  output  1  OR of the unmasked edge flags (level).

Behaviour:
- Clock and reset: single clock clk_i. reset_i is synchronous and active-high.
- Reset values: GPIO_o=0, rdata_o=0, rvalid_o=0, edge_irq_o=0. Internal state also clears: sync FFs=0, debounced value=0, counter=0, EDGE=0, MASK=0.
- Register map (addr_i[3:2]):
  - 0 OUT: read/write. GPIO_o = OUT[WIDTH-1:0].
  - 1 IN: read-only, debounced input zero-extended. Writes are ignored.
  - 2 EDGE: sticky rising-edge flags. Reading has no side effects. A write clears each bit where wdata_i=1 (write-1-to-clear).
  - 3 MASK: read/write. edge_irq_o = |(EDGE & MASK).
- Upper bits [31:WIDTH] always read 0 and are ignored on write.
- Input path:
  - 2-FF synchronizer on GPIO_i produces sync.
  - Debounce FSM with states IDLE and COUNT, running on the whole vector.
    - IDLE: if sync != deb, go to COUNT with cnt=1.
    - COUNT: if sync != cand (cand is the value latched on entry to COUNT), restart with cand=sync and cnt=1. If sync == deb, return to IDLE. If cnt == DEBOUNCE_CYCLES, set deb=cand and return to IDLE. Otherwise cnt++.
  - Latency from a stable change on GPIO_i to an updated IN register: 2 sync cycles + DEBOUNCE_CYCLES + 1.
  - Edge detect: in the cycle deb updates, EDGE |= (new_deb & ~old_deb). Falling edges set no flags.
- Write timing: a write takes effect at the clock edge where sel_i & we_i = 1. GPIO_o changes on that edge, so it is visible the following cycle.
- Read timing: fixed 1-cycle latency.
  - A load sampled at edge N (sel_i & re_i) produces rdata_o and rvalid_o=1 during cycle N+1.
  - rvalid_o is 0 in every other cycle. rdata_o holds its last value when rvalid_o=0.
- Simultaneous events:
  - we_i and re_i both set: the write executes and the read returns the pre-write value.
  - W1C clear of an EDGE bit in the same cycle a new rising edge sets that bit: the set wins and the bit stays 1.
  - A write to the IN register has no effect.
- Unqualified strobes: we_i or re_i with sel_i=0 is ignored; no rvalid_o pulse is generated.
- Reset mid-operation:
  - Reset mid-debounce abandons the candidate value; IN reads 0 afterwards.
  - Reset in the cycle after a load suppresses the rvalid_o pulse.
  - Reset overrides any access in the same cycle.
- Back-to-back loads every cycle produce rvalid_o every cycle, each with its own data.

Test Plan:
1. Reset, then GPIO_i=8'h00, then GPIO_i=8'h07 held stable. IN must read 32'h0 before the change, then 32'h7 after 2+4+1 = 7 cycles. EDGE must read 32'h7.
2. Store 32'hA5 to OUT. GPIO_o must be 8'hA5 on the next cycle; a load of OUT returns 32'hA5 with rvalid_o high exactly one cycle after the strobe.
3. Glitch: GPIO_i toggles 8'h00 -> 8'h01 -> 8'h00 with each level held for 2 cycles. IN must stay 0 and EDGE must stay 0.
4. With EDGE=8'h07 and MASK=8'h02, edge_irq_o=1. Store 32'h02 to EDGE: EDGE=8'h05 and edge_irq_o=0. Issue a W1C of bit 0 in the same cycle as a new bit-0 rise: bit 0 must remain 1.
5. Same-cycle we_i and re_i to OUT (old value 8'h11, new value 8'h22): rdata_o=32'h11, GPIO_o=8'h22. Strobes with sel_i=0 must not change OUT and must not pulse rvalid_o.
6. Assert reset_i for 1 cycle midway through the debounce count of an 8'hFF input. All outputs must read 0 afterwards, and IN must reach 8'hFF only after a full new debounce period.
